clk_en_gen: RTL and testbench
=============================

// Module: clk_en_gen
// PURPOSE
// - Parametrised, lock-qualified clock-enable generator that sits downstream of the MMCM clock wrapper.
// - Derives NUM_CH independent single-cycle enable strobes from one clock, each at a runtime divide ratio.
// - Strobes run only after the PLL/MMCM lock has been stable for LOCK_WAIT cycles.
// - Adds per-channel divisors, glitch-free divisor update, lock-loss recovery and a global phase-realign input.
// PARAMETERS
// - NUM_CH     default 4    number of enable channels (1..16)
// - DIV_W      default 16   divisor width per channel
// - LOCK_WAIT  default 256  consecutive synchronised-lock cycles required before RUN (>=1)
// - SYNC_STG   default 2    lock synchroniser depth (>=2)
// PORTS
// - i_clk      in   1             system clock (MMCM output)
// - i_reset_n  in   1             asynchronous active-low reset
// - i_locked   in   1             MMCM LOCKED, asynchronous to i_clk
// - i_div      in   NUM_CH*DIV_W  per-channel divisor; channel n uses bits [n*DIV_W +: DIV_W]
// - i_realign  in   1             single-cycle pulse that restarts all channel counters in phase
// - o_ready    out  1             high while FSM is in RUN
// - o_ce       out  NUM_CH        per-channel one-cycle enable strobes
// - o_lost     out  1             sticky; set on lock loss from RUN, cleared by reset only
// BEHAVIOUR
// - Reset: all flops clear asynchronously when i_reset_n=0. o_ready=0, o_ce=0, o_lost=0, FSM=WAIT_LOCK, counters=0.
// - Lock sync: i_locked passes through a SYNC_STG-flop synchroniser to form lk_s; no logic samples raw i_locked.
// - FSM states: WAIT_LOCK, SETTLE, RUN.
//   - WAIT_LOCK -> SETTLE when lk_s=1; settle counter loads 1.
//   - SETTLE: counter increments each cycle while lk_s=1. -> RUN on the cycle the counter reaches LOCK_WAIT. -> WAIT_LOCK if lk_s=0.
//   - RUN -> WAIT_LOCK when lk_s=0. o_lost sets on the same edge.
// - o_ready is registered: high in every cycle the FSM is in RUN, low otherwise.
// - Channel divisor: div_eff = (i_div[n] < 2) ? 1 : i_div[n].
//   - div_act[n] loads div_eff on the first RUN cycle, on each terminal count and on realign.
//   - i_div changes mid-period take effect only at the next terminal count; no short or long strobe gaps.
// - Channel counter:
//   - cnt[n] is 0 in the first RUN cycle, then increments.
//   - Terminal count is cnt[n] == div_act[n]-1; cnt[n] wraps to 0 on terminal count.
// - Strobe: o_ce[n] is registered and high for exactly one cycle after each terminal-count cycle.
//   - Latency: with div=D, strobes occur in RUN cycles D, 2D, 3D, ... (first RUN cycle = 0).
//   - div_eff=1: o_ce[n] is high continuously from RUN cycle 1.
// - Realign: i_realign=1 in RUN forces every cnt to 0 and reloads every div_act on the next edge.
//   - A terminal count in the same cycle still produces its strobe.
//   - Realign wins over wrap/increment for the counter value.
//   - i_realign outside RUN is ignored.
// - Lock loss: the edge that leaves RUN clears all cnt and o_ce. No strobe is issued after o_ready falls.
//   - A strobe already registered in the last RUN cycle is suppressed.
// - Reset mid-RUN: all outputs drop asynchronously. The full WAIT_LOCK/SETTLE sequence is repeated.
// STRUCTURE
// - Package clk_en_gen_pkg holds:
//   - typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} clk_en_state_t;
//   - function div_eff(); settle counter width = $clog2(LOCK_WAIT+1).
// - Sub-module clk_en_div_chan: one channel (div_act, cnt, o_ce), instantiated NUM_CH times in a generate loop.
//   - Inputs: run, realign, div.
// - Top level holds the synchroniser, FSM, settle counter and o_lost.
// TESTING
// - Reset/settle: LOCK_WAIT=8, i_locked=1 from t0.
//   - Required: o_ready rises exactly SYNC_STG+8+1 cycles after first sampled edge.
//   - Required: o_ce=0 until then.
// - Divide: div={1,2,3,7}.
//   - Required: ch0 high every RUN cycle from cycle 1.
//   - Required: ch1 at 2,4,6; ch2 at 3,6,9; ch3 at 7,14.
//   - Required: exactly one-cycle pulses.
// - Update: ch3 div 7->4 at RUN cycle 3.
//   - Required: strobe at 7, then 11, 15 (no strobe at 4 or 8).
//   - Required: div 0 behaves as 1.
// - Realign: pulse at RUN cycle 5 with div={2,3,5,5}.
//   - Required: all counters restart.
//   - Required: ch2/ch3 strobe at cycles 11 and 16; ch1 at 9, 12.
// - Lock loss: drop i_locked for 3 cycles in RUN.
//   - Required: o_ready and all o_ce low SYNC_STG+1 cycles later; o_lost=1 and stays set.
//   - Required: full SETTLE repeats before strobes resume from cycle 0 phase.
// - Glitch in SETTLE: 1-cycle low on lk_s at settle count 5.
//   - Required: returns to WAIT_LOCK; RUN only after 8 fresh consecutive cycles.
//   - Required: assert i_reset_n low mid-RUN -> outputs 0 immediately.

Source files
------------

// File: rtl/clk_en_gen_pkg.sv
// clk_en_gen_pkg: shared FSM state type and divisor helper for the clock-enable generator.
package clk_en_gen_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} clk_en_state_t;
  // Divisors 0 and 1 both mean "strobe every cycle".
  function automatic logic [31:0] div_eff(input logic [31:0] d);
    return (d < 32'd2) ? 32'd1 : d;
  endfunction
endpackage

// File: rtl/clk_en_div_chan.sv
// clk_en_div_chan: one enable channel with period-boundary divisor update and realign.
module clk_en_div_chan
  import clk_en_gen_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             realign,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);
  logic [DIV_W-1:0] div_act, cnt, eff, d;
  logic             was_run, tc;
  // The first run cycle has no latched divisor yet, so it uses the live one.
  always_comb begin
    eff = DIV_W'(div_eff(32'(div)));
    d   = was_run ? div_act : eff;
    tc  = cnt == d - DIV_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      was_run <= 1'b0;
      ce      <= 1'b0;
      cnt     <= '0;
      div_act <= '0;
    end else begin
      was_run <= run;
      ce      <= run && tc;
      cnt     <= (run && !realign && !tc) ? cnt + DIV_W'(1) : '0;
      div_act <= (run && (realign || tc)) ? eff : d;
    end
  end
endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: lock-qualified multi-channel clock-enable generator.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 16,
  parameter int LOCK_WAIT = 256,
  parameter int SYNC_STG  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_locked,
  input  logic [NUM_CH*DIV_W-1:0] i_div,
  input  logic                    i_realign,
  output logic                    o_ready,
  output logic [NUM_CH-1:0]       o_ce,
  output logic                    o_lost
);
  localparam int SW = $clog2(LOCK_WAIT + 1);
  logic [SYNC_STG-1:0] sync;
  logic [SW-1:0]       scnt;
  logic                lk_s, run, realign;
  clk_en_state_t       state, nxt;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync    <= '0;
      state   <= WAIT_LOCK;
      scnt    <= '0;
      o_ready <= 1'b0;
      o_lost  <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STG-2:0], i_locked};
      state   <= nxt;
      scnt    <= (nxt == SETTLE) ? ((state == SETTLE) ? scnt + SW'(1) : SW'(1)) : '0;
      o_ready <= nxt == RUN;
      o_lost  <= o_lost || (state == RUN && !lk_s);
    end
  end
  always_comb begin
    lk_s = sync[SYNC_STG-1];
    nxt  = !lk_s ? WAIT_LOCK :
           (state == WAIT_LOCK) ? SETTLE :
           (state == SETTLE && scnt == SW'(LOCK_WAIT)) ? RUN : state;
  end
  // Channels only count while staying in RUN, so the exit edge clears them.
  always_comb begin
    run     = state == RUN && lk_s;
    realign = run && i_realign;
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_en_div_chan #(.DIV_W(DIV_W)) u_chan (
      .clk    (i_clk),
      .rst_n  (i_reset_n),
      .run    (run),
      .realign(realign),
      .div    (i_div[i*DIV_W +: DIV_W]),
      .ce     (o_ce[i])
    );
  end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: scoreboard bench with a streak/deadline reference model for clk_en_gen.
module tb_clk_en_gen;
  localparam int NUM_CH = 4, DIV_W = 16, LOCK_WAIT = 8, SYNC_STG = 2;
  logic clk = 1'b0, rst_n = 1'b0, locked = 1'b0, realign = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div = '0;
  logic ready, lost;
  logic [NUM_CH-1:0] ce;
  clk_en_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_WAIT(LOCK_WAIT), .SYNC_STG(SYNC_STG)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_locked(locked), .i_div(div), .i_realign(realign),
    .o_ready(ready), .o_ce(ce), .o_lost(lost)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic ready; logic lost; logic [NUM_CH-1:0] ce;} exp_t;
  exp_t q[$];
  int vectors = 0, errors = 0;
  bit lkq[$];
  int streak, t;
  bit in_run, mlost;
  int term[NUM_CH];
  function automatic int deff(input int d);
    return (d < 2) ? 1 : d;
  endfunction
  // Reference: RUN once the synchronised lock has been seen high LOCK_WAIT+1 times
  // in a row; each channel strobes the cycle after its period deadline.
  always @(posedge clk) begin : model
    exp_t e;
    bit lk, was;
    int d;
    e = '0;
    if (!rst_n) begin
      lkq = {};
      for (int i = 0; i < SYNC_STG; i++) lkq.push_back(1'b0);
      streak = 0; t = 0; in_run = 0; mlost = 0;
    end else begin
      lk = lkq[SYNC_STG-1];
      was = in_run;
      if (was && lk) begin
        for (int n = 0; n < NUM_CH; n++) begin
          d = deff(int'(div[n*DIV_W +: DIV_W]));
          if (t == 0) term[n] = d - 1;
          e.ce[n] = (t == term[n]);
          if (realign || t == term[n]) term[n] = t + d;
        end
        t++;
      end
      streak = lk ? streak + 1 : 0;
      in_run = streak > LOCK_WAIT;
      if (was && !in_run) mlost = 1;
      if (!in_run) t = 0;
      lkq.push_front(locked);
      void'(lkq.pop_back());
      e.ready = in_run;
      e.lost = mlost;
    end
    q.push_back(e);
  end
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if ({ready, lost, ce} !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got ready=%b lost=%b ce=%b, want ready=%b lost=%b ce=%b",
                 $time, ready, lost, ce, e.ready, e.lost, e.ce);
      end
    end
  end
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_div(input int a, input int b, input int c, input int d);
    div = {DIV_W'(d), DIV_W'(c), DIV_W'(b), DIV_W'(a)};
  endtask
  task automatic wait_ready(input int lim, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ready && k < lim);
  endtask
  initial begin
    int k, drop, ch;
    locked = 1'b1;
    set_div(1, 2, 3, 7);
    cyc(2);
    rst_n = 1'b1;
    wait_ready(100, k);
    check("settle_len", k, SYNC_STG + LOCK_WAIT + 1);
    cyc(3);
    div[3*DIV_W +: DIV_W] = DIV_W'(4);
    cyc(10);
    div[0 +: DIV_W] = '0;
    cyc(17);
    locked = 1'b0;
    cyc(3);
    locked = 1'b1;
    set_div(2, 3, 5, 5);
    wait_ready(200, k);
    check("relock_ready", ready, 1);
    cyc(5);
    realign = 1'b1;
    cyc(1);
    realign = 1'b0;
    cyc(20);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", ready, 0);
    check("rst_ce", ce, 0);
    check("rst_lost", lost, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    locked = 1'b0;
    cyc(1);
    locked = 1'b1;
    wait_ready(100, k);
    check("glitch_len", k, SYNC_STG + LOCK_WAIT + 1);
    drop = 0;
    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        ch = $urandom_range(0, NUM_CH - 1);
        div[ch*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 9));
      end
      realign = ($urandom_range(0, 15) == 0);
      if (drop > 0) begin
        drop--;
        if (drop == 0) locked = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        locked = 1'b0;
        drop = $urandom_range(1, 4);
      end
    end
    realign = 1'b0;
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
